// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BAUD_W = 13;

  localparam logic [BAUD_W-1:0] BAUD_RST_DEF = 13'd433;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of valid at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] pos;

  // Scan from ptr upward, wrapping at N; the first hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!any && valid[pos[IW-1:0]]) begin
        idx = pos[IW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-atomic round-robin scheduler feeding N_REQ byte streams to one UART TX.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned       N_REQ     = 4,
  parameter logic [CNT_W-1:0]  TO_CYCLES = 16'd10000,
  parameter logic [BAUD_W-1:0] BAUD_RST  = BAUD_RST_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [BAUD_W-1:0]        cfg_baud,
  input  logic                     err_clr,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic [BAUD_W-1:0]        uart_ctrl_tx,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err_timeout
);

  localparam int unsigned IW  = $clog2(N_REQ);
  localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

  state_e           state;
  state_e           state_n;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             hs;
  logic             advance;
  logic             expire;
  logic             last_q;
  logic [CNT_W-1:0] cnt;
  logic [IW:0]      ptr_inc;
  logic [IW-1:0]    ptr_next;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state, handshake and end-of-packet decode.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    hs        = 1'b0;
    advance   = 1'b0;
    expire    = 1'b0;
    ptr_inc   = {1'b0, grant_id} + (IW+1)'(1);
    ptr_next  = (ptr_inc == N_W) ? '0 : ptr_inc[IW-1:0];
    case (state)
      ST_IDLE: begin
        if (pick_any) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        req_ready[grant_id] = req_valid[grant_id];
        hs                  = req_valid[grant_id];
        if (hs) state_n = ST_START;
      end
      ST_START: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done has priority over a watchdog expiry in the same cycle.
        if (tx_done) begin
          if (last_q) begin
            advance = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_LOAD;
          end
        end else if (cnt == TO_CYCLES - CNT_W'(2)) begin
          // Flag rises together with the counter reaching TO_CYCLES-1.
          expire  = 1'b1;
          advance = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Datapath, pointer, watchdog and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      uart_ctrl_tx <= BAUD_RST;
      busy         <= 1'b0;
      grant_id     <= '0;
      rr_ptr       <= '0;
      err_timeout  <= 1'b0;
      cnt          <= '0;
      last_q       <= 1'b0;
    end else begin
      tx_start <= hs;
      busy     <= (state_n != ST_IDLE);
      if (state == ST_IDLE) begin
        uart_ctrl_tx <= cfg_baud;
        if (pick_any) grant_id <= pick_idx;
      end
      if (hs) begin
        tx_data <= req_data[{grant_id, 3'b000} +: 8];
        last_q  <= req_last[grant_id];
      end
      if (state == ST_START)     cnt <= '0;
      else if (state == ST_WAIT) cnt <= cnt + CNT_W'(1);
      if (advance) rr_ptr <= ptr_next;
      if (expire)       err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester queues, transmitter model, scenario tasks.
module tb_uart_tx_sched;

  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic          clk          = 1'b0;
  logic          rst          = 1'b1;
  logic [NR-1:0] req_valid    = '0;
  logic [8*NR-1:0] req_data   = '0;
  logic [NR-1:0] req_last     = '0;
  logic [NR-1:0] req_ready;
  logic [12:0]   cfg_baud     = 13'd100;
  logic          err_clr      = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done      = 1'b0;
  logic [12:0]   uart_ctrl_tx;
  logic          busy;
  logic [1:0]    grant_id;
  logic          err_timeout;

  exp_t       exp_q[$];
  logic [8:0] rq[NR][$];
  int         start_q[$];
  int checks = 0, errors = 0, cyc = 0, starts = 0;
  int done_dly = 0, dcnt = 0, hs_cyc = 0, idle_cyc = 0;
  logic busy_prev = 1'b0, start_prev = 1'b0;
  logic [NR-1:0] hs_seen = '0;

  uart_tx_sched #(
    .N_REQ     (NR),
    .TO_CYCLES (16'd100),
    .BAUD_RST  (13'd433)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .cfg_baud     (cfg_baud),
    .err_clr      (err_clr),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done      (tx_done),
    .uart_ctrl_tx (uart_ctrl_tx),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // Requester queues, transmitter model and scoreboard.
  initial begin
    exp_t e;
    logic [8:0] head;
    forever begin
      @(negedge clk);
      hs_seen = rst ? '0 : (req_valid & req_ready);
      if (hs_seen != '0) hs_cyc = cyc;
      @(posedge clk);
      #1;
      cyc++;
      tx_done = 1'b0;
      for (int i = 0; i < NR; i++)
        if (hs_seen[i] && rq[i].size() > 0) rq[i].delete(0);
      if (rst) dcnt = 0;
      else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) tx_done = 1'b1;
      end
      if (tx_start === 1'b1) begin
        start_q.push_back(cyc);
        starts++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got id=%0d data=%h want none", grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant_id, tx_data} !== e) begin
            errors++;
            $display("FAIL sb_byte got id=%0d data=%h want id=%0d data=%h",
                     grant_id, tx_data, e.id, e.data);
          end
        end
        checks++;
        if (cyc - hs_cyc != 1) begin
          errors++;
          $display("FAIL hs_to_start got %0d want 1", cyc - hs_cyc);
        end
        checks++;
        if (start_prev) begin
          errors++;
          $display("FAIL start_width got 2+ cycles want 1");
        end
        if (done_dly > 0) dcnt = done_dly;
      end
      start_prev = (tx_start === 1'b1);
      if (busy_prev && busy === 1'b0) idle_cyc = cyc;
      busy_prev = (busy === 1'b1);
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0) begin
          head = rq[i][0];
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = head[7:0];
          req_last[i] = head[8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(r);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (starts >= target) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (busy === 1'b0 && exp_q.size() == 0 && pending() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_baud = 13'd100;
    cycles(2);
    checks++;
    if ({busy, tx_start, tx_data, grant_id, err_timeout, req_ready} !==
        {1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b start=%b data=%h gid=%0d err=%b rdy=%b want zeros",
               busy, tx_start, tx_data, grant_id, err_timeout, req_ready);
    end
    checks++;
    if (uart_ctrl_tx !== 13'd433) begin
      errors++;
      $display("FAIL reset_baud got %0d want 433", uart_ctrl_tx);
    end
    rst = 1'b0;
    step();
    checks++;
    if (uart_ctrl_tx !== 13'd100) begin
      errors++;
      $display("FAIL idle_baud_track got %0d want 100", uart_ctrl_tx);
    end
    cfg_baud = 13'd433;
    step();
    checks++;
    if (uart_ctrl_tx !== 13'd433) begin
      errors++;
      $display("FAIL idle_baud_433 got %0d want 433", uart_ctrl_tx);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    done_dly = 3;
    start_q.delete();
    push_byte(0, 8'h0A, 1'b0); push_byte(0, 8'h0B, 1'b1);
    push_byte(2, 8'hC0, 1'b0); push_byte(2, 8'hC1, 1'b1);
    expect_byte(0, 8'h0A); expect_byte(0, 8'h0B);
    expect_byte(2, 8'hC0); expect_byte(2, 8'hC1);
    wait_idle(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_complete got pending=%0d want 0", exp_q.size()); end
    checks++;
    if (start_q.size() != 4) begin
      errors++;
      $display("FAIL rr_starts got %0d want 4", start_q.size());
    end else begin
      checks++;
      if (start_q[1] - start_q[0] != 5) begin
        errors++;
        $display("FAIL rr_gap_in_pkt got %0d want 5", start_q[1] - start_q[0]);
      end
      checks++;
      if (start_q[2] - start_q[1] != 6) begin
        errors++;
        $display("FAIL rr_gap_next_pkt got %0d want 6", start_q[2] - start_q[1]);
      end
    end
    checks++;
    if (grant_id !== 2'd2) begin errors++; $display("FAIL rr_grant got %0d want 2", grant_id); end
  endtask

  task automatic test_single_packet();
    bit ok;
    done_dly = 20;
    start_q.delete();
    push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
    expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h43);
    wait_idle(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_complete got pending=%0d want 0", exp_q.size()); end
    checks++;
    if (start_q.size() != 3) begin
      errors++;
      $display("FAIL single_starts got %0d want 3", start_q.size());
    end else begin
      checks++;
      if (start_q[1] - start_q[0] != 22 || start_q[2] - start_q[1] != 22) begin
        errors++;
        $display("FAIL single_gap got %0d,%0d want 22,22",
                 start_q[1] - start_q[0], start_q[2] - start_q[1]);
      end
      checks++;
      if (idle_cyc != start_q[2] + 21) begin
        errors++;
        $display("FAIL single_busy_drop got %0d want %0d", idle_cyc, start_q[2] + 21);
      end
    end
    // Pointer now at 1: requester 1 must win over requester 0.
    done_dly = 3;
    push_byte(0, 8'h10, 1'b1); push_byte(1, 8'h11, 1'b1);
    expect_byte(1, 8'h11); expect_byte(0, 8'h10);
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ptr_after_pkt got pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    bit ok;
    int s0;
    done_dly = 3;
    s0 = starts;
    push_byte(1, 8'h51, 1'b0); push_byte(3, 8'h71, 1'b1);
    expect_byte(1, 8'h51); expect_byte(1, 8'h52); expect_byte(3, 8'h71);
    wait_start(s0 + 1, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_first got starts=%0d want %0d", starts, s0 + 1); end
    cycles(50);
    checks++;
    if (starts != s0 + 1 || busy !== 1'b1 || req_ready !== 4'h0 || rq[3].size() != 1) begin
      errors++;
      $display("FAIL stall_hold got starts=%0d busy=%b rdy=%b q3=%0d want %0d 1 0000 1",
               starts, busy, req_ready, rq[3].size(), s0 + 1);
    end
    push_byte(1, 8'h52, 1'b1);
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_resume got pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    int c, t;
    // Withheld tx_done: flag exactly 100 cycles after tx_start.
    done_dly = 0;
    push_byte(2, 8'h99, 1'b1);
    expect_byte(2, 8'h99);
    wait_start(starts + 1, 50, ok);
    c = start_q[start_q.size()-1];
    t = -1;
    for (int k = 0; k < 150; k++) begin
      step();
      if (err_timeout === 1'b1) begin t = cyc; break; end
    end
    checks++;
    if (!ok || t != c + 100) begin errors++; $display("FAIL to_cycle got %0d want %0d", t, c + 100); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got busy=%b want 0", busy); end
    cycles(5);
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", err_timeout); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", err_timeout); end
    // tx_done on the expiry cycle wins.
    done_dly = 99;
    push_byte(2, 8'h98, 1'b1);
    expect_byte(2, 8'h98);
    wait_idle(300, ok);
    checks++;
    if (!ok || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_done_tie got ok=%b err=%b want 1 0", ok, err_timeout);
    end
    // Set and clear together leaves the flag set for that cycle.
    done_dly = 0;
    err_clr = 1'b1;
    push_byte(0, 8'h97, 1'b1);
    expect_byte(0, 8'h97);
    wait_start(starts + 1, 50, ok);
    c = start_q[start_q.size()-1];
    t = -1;
    for (int k = 0; k < 150; k++) begin
      step();
      if (err_timeout === 1'b1) begin t = cyc; break; end
    end
    checks++;
    if (!ok || t != c + 100) begin errors++; $display("FAIL to_set_wins got %0d want %0d", t, c + 100); end
    step();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clr_after got %b want 0", err_timeout); end
    err_clr = 1'b0;
  endtask

  task automatic test_baud();
    bit ok;
    done_dly = 10;
    push_byte(3, 8'h55, 1'b1);
    expect_byte(3, 8'h55);
    wait_start(starts + 1, 50, ok);
    cfg_baud = 13'd216;
    step();
    cycles(5);
    checks++;
    if (!ok || uart_ctrl_tx !== 13'd433) begin
      errors++;
      $display("FAIL baud_frozen got %0d want 433", uart_ctrl_tx);
    end
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      step();
    end
    checks++;
    if (!ok || uart_ctrl_tx !== 13'd433) begin
      errors++;
      $display("FAIL baud_first_idle got ok=%b baud=%0d want 1 433", ok, uart_ctrl_tx);
    end
    step();
    checks++;
    if (uart_ctrl_tx !== 13'd216) begin errors++; $display("FAIL baud_reload got %0d want 216", uart_ctrl_tx); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s0;
    done_dly = 0;
    push_byte(3, 8'hA1, 1'b0); push_byte(3, 8'hA2, 1'b1);
    expect_byte(3, 8'hA1);
    wait_start(starts + 1, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_start got starts=%0d want more", starts); end
    cycles(5);
    rst = 1'b1;
    rq[3].delete();
    step();
    checks++;
    if ({busy, tx_start, tx_data, grant_id, err_timeout, req_ready, uart_ctrl_tx} !==
        {1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 13'd433}) begin
      errors++;
      $display("FAIL rstmid_outputs got busy=%b start=%b data=%h gid=%0d err=%b rdy=%b baud=%0d want 0 0 00 0 0 0000 433",
               busy, tx_start, tx_data, grant_id, err_timeout, req_ready, uart_ctrl_tx);
    end
    rst = 1'b0;
    s0 = starts;
    cycles(20);
    checks++;
    if (starts != s0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_quiet got starts=%0d busy=%b exp=%0d want %0d 0 0",
               starts, busy, exp_q.size(), s0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_packet();
    test_stall();
    test_timeout();
    test_baud();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
